gpio_core: RTL and testbench

Register and pad-control core of the GPIO peripheral, directly downstream of the APB slave interface. It decodes the interface's `gpio_we` / `gpio_addr` / `gpio_dat_i` into seven 32-bit registers and drives the pad outputs and output enables. It synchronises the pad inputs, detects per-bit edges into a sticky interrupt status, and returns `gpio_dat_o` and `gpio_int_o` to the interface.

---
 rtl/gpio_core_if.sv | 31 +++
 rtl/gpio_core.sv | 132 +++++++++++++
 tb/tb_gpio_core.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/gpio_core_if.sv
// rtl/gpio_core_if.sv - register bus between the APB slave and gpio_core
// Purpose: bundles the write strobe, address, data and interrupt lines.
// Ports (signals):
//   gpio_we     write strobe, master -> slave
//   gpio_addr   byte address, master -> slave
//   gpio_dat_i  write data, master -> slave
//   gpio_dat_o  read data, slave -> master
//   gpio_int_o  interrupt request, slave -> master
interface gpio_core_if;
    logic        gpio_we;
    logic [31:0] gpio_addr;
    logic [31:0] gpio_dat_i;
    logic [31:0] gpio_dat_o;
    logic        gpio_int_o;

    modport master (
        output gpio_we,
        output gpio_addr,
        output gpio_dat_i,
        input  gpio_dat_o,
        input  gpio_int_o
    );

    modport slave (
        input  gpio_we,
        input  gpio_addr,
        input  gpio_dat_i,
        output gpio_dat_o,
        output gpio_int_o
    );
endinterface

// File: rtl/gpio_core.sv
// rtl/gpio_core.sv - GPIO register file, pad control and edge interrupts
// Purpose: seven 32-bit registers, pad output/enable drive, input
//          synchroniser, per-bit edge detect into sticky W1C status.
// Ports:
//   sys_clk      clock
//   sys_rst      synchronous active-high reset
//   bus          gpio_core_if.slave register bus (we/addr/dat_i/dat_o/int_o)
//   ext_pad_i    asynchronous pad inputs
//   ext_pad_o    pad output values (RGPIO_OUT)
//   ext_padoe_o  pad output enables (RGPIO_OE)
module gpio_core #(
    parameter int GPIO_WIDTH = 32
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    gpio_core_if.slave            bus,
    input  logic [GPIO_WIDTH-1:0] ext_pad_i,
    output logic [GPIO_WIDTH-1:0] ext_pad_o,
    output logic [GPIO_WIDTH-1:0] ext_padoe_o
);

    localparam logic [2:0] IDX_IN    = 3'd0;
    localparam logic [2:0] IDX_OUT   = 3'd1;
    localparam logic [2:0] IDX_OE    = 3'd2;
    localparam logic [2:0] IDX_INTE  = 3'd3;
    localparam logic [2:0] IDX_PTRIG = 3'd4;
    localparam logic [2:0] IDX_CTRL  = 3'd5;
    localparam logic [2:0] IDX_INTS  = 3'd6;

    logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, sync3_q;
    logic [GPIO_WIDTH-1:0] out_q, out_d;
    logic [GPIO_WIDTH-1:0] oe_q, oe_d;
    logic [GPIO_WIDTH-1:0] inte_q, inte_d;
    logic [GPIO_WIDTH-1:0] ptrig_q, ptrig_d;
    logic [GPIO_WIDTH-1:0] ints_q, ints_d;
    logic                  ctrl_q, ctrl_d;

    logic                  hit;
    logic [2:0]            idx;
    logic [GPIO_WIDTH-1:0] wdata;
    logic [GPIO_WIDTH-1:0] rise, fall, evt, clr;
    logic [31:0]           rdata;
    logic                  unused_addr_hi;

    assign unused_addr_hi = ^bus.gpio_addr[31:8];

    function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
        logic [31:0] r;
        r = '0;
        r[GPIO_WIDTH-1:0] = v;
        return r;
    endfunction

    // Only aligned offsets 0x00..0x18 decode; 0x1C and above, or any
    // unaligned byte address, miss and read as zero.
    assign idx   = bus.gpio_addr[4:2];
    assign hit   = (bus.gpio_addr[1:0] == 2'b00) && (bus.gpio_addr[7:5] == 3'b000)
                   && (idx != 3'd7);
    assign wdata = bus.gpio_dat_i[GPIO_WIDTH-1:0];

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;
    assign evt  = inte_q & ((ptrig_q & rise) | (~ptrig_q & fall));

    always_comb begin
        out_d   = out_q;
        oe_d    = oe_q;
        inte_d  = inte_q;
        ptrig_d = ptrig_q;
        ctrl_d  = ctrl_q;
        clr     = '0;
        if (bus.gpio_we && hit) begin
            case (idx)
                IDX_OUT:   out_d   = wdata;
                IDX_OE:    oe_d    = wdata;
                IDX_INTE:  inte_d  = wdata;
                IDX_PTRIG: ptrig_d = wdata;
                IDX_CTRL:  ctrl_d  = bus.gpio_dat_i[0];
                IDX_INTS:  clr     = wdata;
                default:   ;
            endcase
        end
        // OR-ing the event in after the clear makes a coincident edge win.
        ints_d = (ints_q & ~clr) | evt;
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (idx)
                IDX_IN:    rdata = zext(sync2_q);
                IDX_OUT:   rdata = zext(out_q);
                IDX_OE:    rdata = zext(oe_q);
                IDX_INTE:  rdata = zext(inte_q);
                IDX_PTRIG: rdata = zext(ptrig_q);
                IDX_CTRL:  rdata = {31'd0, ctrl_q};
                IDX_INTS:  rdata = zext(ints_q);
                default:   rdata = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            out_q   <= '0;
            oe_q    <= '0;
            inte_q  <= '0;
            ptrig_q <= '0;
            ints_q  <= '0;
            ctrl_q  <= 1'b0;
        end else begin
            sync1_q <= ext_pad_i;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            out_q   <= out_d;
            oe_q    <= oe_d;
            inte_q  <= inte_d;
            ptrig_q <= ptrig_d;
            ints_q  <= ints_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.gpio_dat_o = rdata;
    assign bus.gpio_int_o = ctrl_q & (|ints_q);
    assign ext_pad_o      = out_q;
    assign ext_padoe_o    = oe_q;

endmodule

// File: tb/tb_gpio_core.sv
// tb/tb_gpio_core.sv - directed self-checking bench for gpio_core
module tb_gpio_core;

    logic        sys_clk;
    logic        sys_rst;
    logic [31:0] ext_pad_i;
    logic [31:0] ext_pad_o;
    logic [31:0] ext_padoe_o;
    int          n_vec;
    int          n_err;

    gpio_core_if bus ();

    gpio_core #(.GPIO_WIDTH(32)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .bus         (bus),
        .ext_pad_i   (ext_pad_i),
        .ext_pad_o   (ext_pad_o),
        .ext_padoe_o (ext_padoe_o)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.gpio_addr = a;
        #1;
        chk(tag, bus.gpio_dat_o, exp);
    endtask

    task automatic chk_int(input string tag, input logic exp);
        #1;
        chk(tag, {31'd0, bus.gpio_int_o}, {31'd0, exp});
    endtask

    // Called at a falling edge; strobe spans exactly one rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.gpio_we    = 1'b1;
        bus.gpio_addr  = a;
        bus.gpio_dat_i = d;
        @(negedge sys_clk);
        bus.gpio_we    = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        sys_rst        = 1'b1;
        ext_pad_i      = '0;
        bus.gpio_we    = 1'b0;
        bus.gpio_addr  = '0;
        bus.gpio_dat_i = '0;
        cyc(2);
        sys_rst = 1'b0;

        // reset state
        rd("rst_in",    32'h00, 32'h0);
        rd("rst_out",   32'h04, 32'h0);
        rd("rst_oe",    32'h08, 32'h0);
        rd("rst_inte",  32'h0C, 32'h0);
        rd("rst_ptrig", 32'h10, 32'h0);
        rd("rst_ctrl",  32'h14, 32'h0);
        rd("rst_ints",  32'h18, 32'h0);
        chk("rst_pad_o",   ext_pad_o,   32'h0);
        chk("rst_padoe_o", ext_padoe_o, 32'h0);
        chk_int("rst_int", 1'b0);

        // register read/write and pad drive
        cyc(1);
        wr(32'h04, 32'hA5A5_5A5A);
        wr(32'h08, 32'h0000_FFFF);
        chk("pad_o",   ext_pad_o,   32'hA5A5_5A5A);
        chk("padoe_o", ext_padoe_o, 32'h0000_FFFF);
        rd("out_rb",    32'h04, 32'hA5A5_5A5A);
        rd("oe_rb",     32'h08, 32'h0000_FFFF);
        rd("out_rb_hi", 32'h8000_0004, 32'hA5A5_5A5A);
        cyc(1);
        wr(32'h00, 32'hFFFF_FFFF);
        wr(32'h1C, 32'hFFFF_FFFF);
        wr(32'h05, 32'hFFFF_FFFF);
        rd("in_ro",    32'h00, 32'h0);
        rd("rd_1c",    32'h1C, 32'h0);
        rd("rd_05",    32'h05, 32'h0);
        rd("out_keep", 32'h04, 32'hA5A5_5A5A);
        rd("oe_keep",  32'h08, 32'h0000_FFFF);
        rd("inte_keep",32'h0C, 32'h0);
        rd("ctrl_keep",32'h14, 32'h0);
        rd("ints_keep",32'h18, 32'h0);

        // input latency
        cyc(1);
        ext_pad_i = 32'h1;
        cyc(1);
        rd("in_e0", 32'h00, 32'h0);
        cyc(1);
        rd("in_e1", 32'h00, 32'h1);
        ext_pad_i = 32'h0;
        cyc(3);

        // rising-edge interrupt
        wr(32'h0C, 32'h1);
        wr(32'h10, 32'h1);
        wr(32'h14, 32'h1);
        ext_pad_i = 32'h1;
        cyc(2);
        rd("rise_ints_e1", 32'h18, 32'h0);
        chk_int("rise_int_e1", 1'b0);
        cyc(1);
        rd("rise_ints_e2", 32'h18, 32'h1);
        chk_int("rise_int_e2", 1'b1);
        cyc(1);
        wr(32'h18, 32'h1);
        rd("w1c_ints", 32'h18, 32'h0);
        chk_int("w1c_int", 1'b0);

        // falling edge with global enable off
        cyc(1);
        wr(32'h14, 32'h0);
        wr(32'h0C, 32'h9);
        ext_pad_i = 32'h9;
        cyc(3);
        rd("fall_rise_ign", 32'h18, 32'h0);
        ext_pad_i = 32'h1;
        cyc(2);
        rd("fall_ints_e1", 32'h18, 32'h0);
        cyc(1);
        rd("fall_ints_e2", 32'h18, 32'h8);
        chk_int("fall_masked", 1'b0);
        cyc(1);
        wr(32'h14, 32'h1);
        chk_int("fall_unmask", 1'b1);
        ext_pad_i = 32'h9;
        cyc(3);
        rd("fall_rise3_ign", 32'h18, 32'h8);
        wr(32'h18, 32'h8);
        rd("fall_clr", 32'h18, 32'h0);

        // edge coinciding with W1C: set wins
        cyc(1);
        ext_pad_i = 32'h8;
        cyc(3);
        ext_pad_i = 32'h9;
        cyc(3);
        rd("race_pre", 32'h18, 32'h1);
        ext_pad_i = 32'h8;
        cyc(3);
        rd("race_hold", 32'h18, 32'h1);
        ext_pad_i = 32'h9;
        cyc(2);
        wr(32'h18, 32'h1);
        rd("race_set_wins", 32'h18, 32'h1);
        chk_int("race_int", 1'b1);

        // W1C strobe held three cycles
        cyc(1);
        bus.gpio_we    = 1'b1;
        bus.gpio_addr  = 32'h18;
        bus.gpio_dat_i = 32'h1;
        cyc(3);
        bus.gpio_we    = 1'b0;
        rd("held_ints",  32'h18, 32'h0);
        chk_int("held_int", 1'b0);
        rd("held_out",   32'h04, 32'hA5A5_5A5A);
        rd("held_inte",  32'h0C, 32'h9);
        rd("held_ptrig", 32'h10, 32'h1);
        rd("held_ctrl",  32'h14, 32'h1);

        // reset beats a simultaneous write
        cyc(1);
        sys_rst        = 1'b1;
        bus.gpio_we    = 1'b1;
        bus.gpio_addr  = 32'h04;
        bus.gpio_dat_i = 32'hFFFF_FFFF;
        cyc(1);
        sys_rst     = 1'b0;
        bus.gpio_we = 1'b0;
        rd("rstwr_out", 32'h04, 32'h0);
        chk("rstwr_pad_o",   ext_pad_o,   32'h0);
        chk("rstwr_padoe_o", ext_padoe_o, 32'h0);
        rd("rstwr_inte", 32'h0C, 32'h0);

        // pad already high at reset release: rise masked by INTE=0
        cyc(3);
        rd("post_rst_in",   32'h00, 32'h9);
        rd("post_rst_ints", 32'h18, 32'h0);
        chk_int("post_rst_int", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
